// File: rtl/l2_pkg.sv
// Shared types and default geometry for the L2 memory-side burst adapter.
package l2_pkg;

  localparam int s_offset = 5;
  localparam int s_line   = 8 * (2 ** s_offset);
  localparam int s_beat   = 64;
  localparam int s_addr   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } l2_burst_state_t;

  typedef logic [s_line-1:0] l2_line_t;

endpackage

// File: rtl/l2_burst_adapter.sv
// Converts one line-wide fill or writeback into a fixed-length burst of
// beat-wide memory transfers; all outputs decode from registered state.
module l2_burst_adapter
  import l2_pkg::*;
#(
  parameter int s_offset = l2_pkg::s_offset,
  parameter int s_line   = 8 * (2 ** s_offset),
  parameter int s_beat   = l2_pkg::s_beat,
  parameter int s_addr   = l2_pkg::s_addr
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l2_read_i,
  input  logic              l2_write_i,
  input  logic [s_addr-1:0] l2_addr_i,
  input  logic [s_line-1:0] l2_line_i,
  output logic [s_line-1:0] l2_line_o,
  output logic              l2_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [s_addr-1:0] mem_addr_o,
  output logic [s_beat-1:0] mem_wdata_o,
  input  logic [s_beat-1:0] mem_rdata_i,
  input  logic              mem_resp_i
);

  localparam int num_beats = s_line / s_beat;
  localparam int cnt_w     = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);
  localparam logic [s_addr-1:0] addr_mask = ~((s_addr'(1) << s_offset) - s_addr'(1));

  l2_burst_state_t   state_q, state_d;
  logic [cnt_w-1:0]  cnt_q, cnt_d;
  logic [s_addr-1:0] addr_q, addr_d;
  logic [s_line-1:0] line_q, line_d;

  // State, beat counter, address and line registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  // Next-state, beat sequencing and line assembly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        // A simultaneous read is dropped; writeback has priority.
        if (l2_write_i) begin
          state_d = WRITE;
          addr_d  = l2_addr_i & addr_mask;
          line_d  = l2_line_i;
        end else if (l2_read_i) begin
          state_d = READ;
          addr_d  = l2_addr_i & addr_mask;
        end else begin
          state_d = IDLE;
        end
      end
      READ, WRITE: begin
        if (mem_resp_i) begin
          if (state_q == READ) begin
            line_d[s_beat*cnt_q +: s_beat] = mem_rdata_i;
          end else begin
            line_d = line_q;
          end
          if (cnt_q == last_beat) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from registered state and data only.
  always_comb begin
    l2_line_o   = line_q;
    mem_addr_o  = addr_q;
    l2_resp_o   = (state_q == DONE);
    mem_read_o  = (state_q == READ);
    mem_write_o = (state_q == WRITE);
    if (state_q == WRITE) begin
      mem_wdata_o = line_q[s_beat*cnt_q +: s_beat];
    end else begin
      mem_wdata_o = '0;
    end
  end

endmodule
